// File: rtl/conv_seq_ctrl_if.sv
// Control/stream handshake bundle between the convolution sequencer
// and the surrounding memories, datapath and output consumer.
interface conv_seq_ctrl_if #(
  parameter int AW = 7
) ();
  logic          conv_start;
  logic          m_ready_y;
  logic [AW-1:0] load_xaddr_val;
  logic          en_pline_stages;
  logic          m_valid_y;
  logic          conv_done;
  logic          busy;

  modport slave (
    input  conv_start,
    input  m_ready_y,
    output load_xaddr_val,
    output en_pline_stages,
    output m_valid_y,
    output conv_done,
    output busy
  );

  modport master (
    output conv_start,
    output m_ready_y,
    input  load_xaddr_val,
    input  en_pline_stages,
    input  m_valid_y,
    input  conv_done,
    input  busy
  );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Sequencer for a stall-all multiply/adder-tree convolution pipeline:
// issues window offsets, tracks in-flight valids, counts outputs.
module conv_seq_ctrl #(
  parameter int X_SIZE           = 128,
  parameter int F_SIZE           = 32,
  parameter int PLINE_STAGES     = 5,
  parameter int X_MEM_ADDR_WIDTH = $clog2(X_SIZE)
) (
  input  logic            clk,
  input  logic            reset,
  conv_seq_ctrl_if.slave  cs
);

  localparam int N_OUT = X_SIZE - F_SIZE + 1;
  localparam int CW    = $clog2(N_OUT + 1);

  localparam logic [CW-1:0] N_OUT_C = CW'(N_OUT);
  localparam logic [CW-1:0] LAST_C  = CW'(N_OUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           issue_q;
  logic [CW-1:0]           out_cnt_q;
  logic [PLINE_STAGES-1:0] vld_q;
  logic                    done_q;
  logic                    busy_q;

  logic                    valid;
  logic                    en;
  logic                    hs;
  logic                    issue_ok;
  logic [CW-1:0]           addr_d;

  always_comb begin
    valid    = vld_q[PLINE_STAGES-1];
    en       = (state_q == RUN) && (!valid || cs.m_ready_y);
    hs       = valid && cs.m_ready_y && (state_q == RUN);
    issue_ok = issue_q < N_OUT_C;
    addr_d   = issue_ok ? issue_q : LAST_C;
  end

  assign cs.load_xaddr_val  = X_MEM_ADDR_WIDTH'(addr_d);
  assign cs.en_pline_stages = en;
  assign cs.m_valid_y       = valid;
  assign cs.conv_done       = done_q;
  assign cs.busy            = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      issue_q   <= '0;
      out_cnt_q <= '0;
      vld_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cs.conv_start) begin
            state_q   <= RUN;
            busy_q    <= 1'b1;
            issue_q   <= '0;
            out_cnt_q <= '0;
            vld_q     <= '0;
          end
        end
        RUN: begin
          if (!cs.conv_start) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            vld_q   <= '0;
          end else begin
            if (en) begin
              vld_q <= {vld_q[PLINE_STAGES-2:0], issue_ok};
              if (issue_ok) issue_q <= issue_q + 1'b1;
            end
            if (hs) begin
              out_cnt_q <= out_cnt_q + 1'b1;
              // final result accepted: flush and pulse done
              if (out_cnt_q == LAST_C) begin
                state_q <= DONE;
                done_q  <= 1'b1;
                vld_q   <= '0;
              end
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          vld_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl: full-rate, stalled, toggled,
// reset-mid-run and aborted convolutions at default parameters.
module tb_conv_seq_ctrl;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  conv_seq_ctrl_if #(.AW(7)) ifc ();

  conv_seq_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .cs    (ifc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [6:0] pipe [5];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) pipe[i] <= '0;
    end else if (ifc.en_pline_stages) begin
      pipe[0] <= ifc.load_xaddr_val;
      for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
    end
  end

  int first_v, last_v, valid_cnt, hs, order_err;
  int done_cnt, done_cyc, busy_first, busy_low, max_addr;
  int stall_err, restart_err, abort_ok, timed_out;
  logic busy0;
  logic [10:0] rst_vals;

  task automatic run(input int pat);
    int cyc;
    int after;
    int drop_cyc;
    bit drop;
    bit fin;
    logic [6:0] frz;
    first_v = -1; last_v = -1; valid_cnt = 0; hs = 0;
    order_err = 0; done_cnt = 0; done_cyc = -1;
    busy_first = -1; busy_low = -1; max_addr = 0;
    stall_err = 0; restart_err = 0; abort_ok = 0;
    timed_out = 0; rst_vals = '1;
    after = 0; drop = 0; drop_cyc = -1; fin = 0; frz = '0;
    @(negedge clk);
    ifc.conv_start = 1'b1;
    ifc.m_ready_y  = (pat == 2) ? 1'b0 : 1'b1;
    #1 busy0 = ifc.busy;
    cyc = 1;
    while (!fin && cyc < 400) begin
      @(posedge clk);
      #1;
      ifc.conv_start = !drop;
      case (pat)
        1: ifc.m_ready_y = !(cyc >= 10 && cyc <= 19);
        2: ifc.m_ready_y = cyc[0];
        default: ifc.m_ready_y = 1'b1;
      endcase
      @(negedge clk);
      if (ifc.busy && busy_first < 0) busy_first = cyc;
      if (!ifc.busy && busy_first >= 0 && busy_low < 0)
        busy_low = cyc;
      if (ifc.m_valid_y) begin
        valid_cnt++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (int'(ifc.load_xaddr_val) > max_addr)
        max_addr = int'(ifc.load_xaddr_val);
      if (done_cyc >= 0 && (ifc.busy || ifc.en_pline_stages))
        restart_err++;
      if (ifc.conv_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pat == 1 && cyc == 10) frz = ifc.load_xaddr_val;
      if (pat == 1 && cyc >= 10 && cyc <= 19) begin
        if (!(ifc.m_valid_y && !ifc.en_pline_stages &&
              ifc.load_xaddr_val == frz && pipe[4] == 7'd4))
          stall_err++;
      end
      if (ifc.m_valid_y && ifc.m_ready_y) begin
        if (int'(pipe[4]) != hs) order_err++;
        hs++;
      end
      if (pat == 4 && hs == 40) begin
        reset = 1'b1;
        #1 rst_vals = {ifc.load_xaddr_val, ifc.en_pline_stages,
                       ifc.m_valid_y, ifc.conv_done, ifc.busy};
        fin = 1;
      end
      if (pat == 3 && hs >= 20 && !drop) begin
        drop = 1;
        drop_cyc = cyc;
      end
      if (pat == 3 && drop_cyc >= 0 && cyc == drop_cyc + 2)
        abort_ok = (!ifc.busy && !ifc.m_valid_y) ? 1 : 0;
      if (pat == 3 && drop_cyc >= 0 && cyc == drop_cyc + 4) fin = 1;
      if (done_cyc >= 0) begin
        drop = 1;
        after++;
        if (after >= 5) fin = 1;
      end
      cyc++;
    end
    if (!fin) timed_out = 1;
    ifc.conv_start = 1'b0;
    ifc.m_ready_y  = 1'b1;
  endtask

  task automatic test_reset;
    logic [10:0] v;
    ifc.conv_start = 1'b0;
    ifc.m_ready_y  = 1'b1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    v = {ifc.load_xaddr_val, ifc.en_pline_stages,
         ifc.m_valid_y, ifc.conv_done, ifc.busy};
    total++;
    if (v !== 11'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", v);
    end
    ifc.conv_start = 1'b1;
    @(negedge clk);
    total++;
    if (ifc.busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_holds_idle got=%b want=0", ifc.busy);
    end
    ifc.conv_start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_rate;
    run(0);
    total++;
    if (timed_out != 0) begin
      bad++; $display("FAIL full_timeout got=%0d want=0", timed_out);
    end
    total++;
    if (busy0 !== 1'b0) begin
      bad++; $display("FAIL full_busy_c0 got=%b want=0", busy0);
    end
    total++;
    if (busy_first != 1) begin
      bad++; $display("FAIL full_run_cyc got=%0d want=1", busy_first);
    end
    total++;
    if (first_v != 6) begin
      bad++; $display("FAIL full_first_valid got=%0d want=6", first_v);
    end
    total++;
    if (last_v != 102) begin
      bad++; $display("FAIL full_last_valid got=%0d want=102", last_v);
    end
    total++;
    if (valid_cnt != 97) begin
      bad++; $display("FAIL full_valid_cnt got=%0d want=97", valid_cnt);
    end
    total++;
    if (hs != 97 || order_err != 0) begin
      bad++;
      $display("FAIL full_handshakes got=%0d/%0d want=97/0",
               hs, order_err);
    end
    total++;
    if (done_cyc != 103 || done_cnt != 1) begin
      bad++;
      $display("FAIL full_done got=%0d x%0d want=103 x1",
               done_cyc, done_cnt);
    end
    total++;
    if (busy_low != 104) begin
      bad++; $display("FAIL full_busy_low got=%0d want=104", busy_low);
    end
    total++;
    if (max_addr != 96) begin
      bad++; $display("FAIL full_max_addr got=%0d want=96", max_addr);
    end
    total++;
    if (restart_err != 0) begin
      bad++; $display("FAIL no_restart got=%0d want=0", restart_err);
    end
  endtask

  task automatic test_stall;
    run(1);
    total++;
    if (stall_err != 0) begin
      bad++; $display("FAIL stall_hold got=%0d want=0", stall_err);
    end
    total++;
    if (hs != 97 || order_err != 0) begin
      bad++;
      $display("FAIL stall_handshakes got=%0d/%0d want=97/0",
               hs, order_err);
    end
    total++;
    if (valid_cnt != 107) begin
      bad++; $display("FAIL stall_valid_cnt got=%0d want=107", valid_cnt);
    end
    total++;
    if (done_cyc != 113 || done_cnt != 1) begin
      bad++;
      $display("FAIL stall_done got=%0d x%0d want=113 x1",
               done_cyc, done_cnt);
    end
  endtask

  task automatic test_toggle;
    run(2);
    total++;
    if (hs != 97 || order_err != 0) begin
      bad++;
      $display("FAIL toggle_handshakes got=%0d/%0d want=97/0",
               hs, order_err);
    end
    total++;
    if (max_addr != 96) begin
      bad++; $display("FAIL toggle_max_addr got=%0d want=96", max_addr);
    end
    total++;
    if (done_cnt != 1 || timed_out != 0) begin
      bad++;
      $display("FAIL toggle_done got=%0d to=%0d want=1 to=0",
               done_cnt, timed_out);
    end
  endtask

  task automatic test_reset_mid;
    run(4);
    total++;
    if (rst_vals !== 11'd0) begin
      bad++; $display("FAIL midreset_outputs got=%b want=0", rst_vals);
    end
    total++;
    if (done_cnt != 0 || hs != 40) begin
      bad++;
      $display("FAIL midreset_progress got=%0d/%0d want=0/40",
               done_cnt, hs);
    end
    @(negedge clk);
    reset = 1'b0;
    run(0);
    total++;
    if (first_v != 6 || hs != 97 || order_err != 0) begin
      bad++;
      $display("FAIL rerun got=%0d/%0d/%0d want=6/97/0",
               first_v, hs, order_err);
    end
    total++;
    if (done_cyc != 103) begin
      bad++; $display("FAIL rerun_done got=%0d want=103", done_cyc);
    end
  endtask

  task automatic test_abort;
    run(3);
    total++;
    if (abort_ok != 1) begin
      bad++; $display("FAIL abort_idle got=%0d want=1", abort_ok);
    end
    total++;
    if (done_cnt != 0) begin
      bad++; $display("FAIL abort_no_done got=%0d want=0", done_cnt);
    end
    total++;
    if (hs != 21 || order_err != 0) begin
      bad++;
      $display("FAIL abort_handshakes got=%0d/%0d want=21/0",
               hs, order_err);
    end
  endtask

  initial begin
    ifc.conv_start = 1'b0;
    ifc.m_ready_y  = 1'b1;
    test_reset;
    test_full_rate;
    test_stall;
    test_toggle;
    test_reset_mid;
    test_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
